// File: rtl/rob_commit_unit.sv
// In-order retirement buffer: issue allocates at the tail, the CDB completes entries,
// and the head entry retires once done. A retired mispredicted branch flushes everything.
module rob_commit_unit #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_idx,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [IDX_W-1:0]  q1_idx,
    input  logic [IDX_W-1:0]  q2_idx,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_we,
    output logic              commit_is_store,
    output logic              flush,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    localparam int unsigned CntW = IDX_W + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
    localparam logic [3:0] FuncLoad  = 4'b0100;
    localparam logic [3:0] FuncStore = 4'b0101;

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  mispred_q;
    logic [3:0]        func_q  [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];

    logic [IDX_W-1:0] head_q, tail_q;
    logic [CntW-1:0]  count_q;

    logic alloc_fire, commit_fire, commit_flush;

    // flush_q blocks allocation for the cycle the flush pulse is visible
    assign alloc_ready  = (count_q != FullCount) && !flush;
    assign alloc_idx    = tail_q;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_fire  = busy_q[head_q] && done_q[head_q];
    assign commit_flush = commit_fire && mispred_q[head_q];
    assign count        = count_q;
    assign empty        = (count_q == '0);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (commit_flush) begin
            busy_q    <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            if (cdb_valid && busy_q[cdb_idx]) begin
                done_q[cdb_idx]    <= 1'b1;
                value_q[cdb_idx]   <= cdb_data;
                mispred_q[cdb_idx] <= cdb_mispredict;
            end
            if (alloc_fire) begin
                busy_q[tail_q]    <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                mispred_q[tail_q] <= 1'b0;
                func_q[tail_q]    <= alloc_func;
                rd_q[tail_q]      <= alloc_rd;
            end
            // head never equals tail here: a commit implies 0 < count, an alloc count < DEPTH
            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (commit_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail_q <= tail_q + 1'b1;
            end
            if (commit_fire) begin
                head_q <= head_q + 1'b1;
            end
            if (alloc_fire && !commit_fire) begin
                count_q <= count_q + 1'b1;
            end else if (!alloc_fire && commit_fire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid    <= 1'b0;
            flush           <= 1'b0;
            commit_idx      <= '0;
            commit_rd       <= '0;
            commit_data     <= '0;
            commit_we       <= 1'b0;
            commit_is_store <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            flush        <= commit_flush;
            if (commit_fire) begin
                commit_idx      <= head_q;
                commit_rd       <= rd_q[head_q];
                commit_data     <= value_q[head_q];
                commit_we       <= (func_q[head_q] <= FuncLoad);
                commit_is_store <= (func_q[head_q] == FuncStore);
            end else begin
                commit_we       <= 1'b0;
                commit_is_store <= 1'b0;
            end
        end
    end

    logic [IDX_W-1:0]  q_idx [2];
    logic              q_rdy [2];
    logic [DATA_W-1:0] q_val [2];

    assign q_idx[0] = q1_idx;
    assign q_idx[1] = q2_idx;
    assign q1_ready = q_rdy[0];
    assign q1_data  = q_val[0];
    assign q2_ready = q_rdy[1];
    assign q2_data  = q_val[1];

    // A same-cycle CDB broadcast to a live entry bypasses the stored value
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_rdy[p] = 1'b0;
            q_val[p] = '0;
            if (busy_q[q_idx[p]]) begin
                if (cdb_valid && (cdb_idx == q_idx[p])) begin
                    q_rdy[p] = 1'b1;
                    q_val[p] = cdb_data;
                end else begin
                    q_rdy[p] = done_q[q_idx[p]];
                    q_val[p] = value_q[q_idx[p]];
                end
            end
        end
    end

endmodule
